// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// Contents: sequencer state encoding, init-value helper.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int unsigned INIT_VAL_W = 64;

  // Init value of entry idx: idx itself (truncated to data_w bits) or zero.
  function automatic logic [INIT_VAL_W-1:0] init_val(input int unsigned idx,
                                                     input int unsigned data_w,
                                                     input bit          init_index);
    logic [INIT_VAL_W-1:0] v;
    v = init_index ? INIT_VAL_W'(idx) : '0;
    if (data_w < INIT_VAL_W) begin
      v = v & ((INIT_VAL_W'(1) << data_w) - INIT_VAL_W'(1));
    end
    return v;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus between a datapath stage (master) and the register file (slave).
// master drives en/we/waddr/wdata/raddr_a/raddr_b; slave returns
// rdata_a/rdata_b/ready/wr_err.
interface regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              ready;
  logic              wr_err;

  modport master (
    output en, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, ready, wr_err
  );

  modport slave (
    input  en, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, ready, wr_err
  );

endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset init sequencer: walks every entry once, then declares done.
// Ports: clk, rst (sync, active-high), en (clock enable)
//        init_we   - sequencer owns the write port (INIT state)
//        init_addr - entry being initialised this cycle
//        init_done - sweep complete (READY state)
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam logic [0:0]  ST_INIT  = 1'(RF_INIT);
  localparam logic [0:0]  ST_READY = 1'(RF_READY);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] init_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State register; rst overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= cnt_nxt;
    end
  end

  // Next state: the extra counter bit flags the end of the sweep.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = init_cnt;
    if (en) begin
      case (state)
        ST_INIT: begin
          cnt_nxt = init_cnt + CNT_W'(1);
          if (cnt_nxt[ADDR_W]) begin
            state_nxt = ST_READY;
          end
        end
        default: state_nxt = ST_READY;
      endcase
    end
  end

  assign init_we   = (state == ST_INIT);
  assign init_addr = init_cnt[ADDR_W-1:0];
  assign init_done = (state == ST_READY);

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two registered read ports with write bypass,
// one write port, self-initialising after reset, optional hardwired zero.
// Ports: clk, rst (sync, active-high)
//        bus (regfile_if.slave): en, we, waddr, wdata, raddr_a, raddr_b in;
//        rdata_a, rdata_b (1-cycle latency), ready, wr_err out.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          INIT_INDEX = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              init_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;
  logic              wr_err_q;

  regfile_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  // Write mux: sequencer during INIT, user port once ready; entry 0 guarded.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.wdata;
    if (!rst && bus.en) begin
      if (!init_done) begin
        mem_we    = init_we;
        mem_waddr = init_addr;
        mem_wdata = DATA_W'(init_val(32'(init_addr), DATA_W, INIT_INDEX));
      end else if (bus.we && !(ZERO_REG && (bus.waddr == '0))) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array; contents survive rst and are rewritten by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read/bypass mux A: zero entry, then same-cycle write, then array.
  always_comb begin
    rd_a = mem[bus.raddr_a];
    if (ZERO_REG && (bus.raddr_a == '0)) begin
      rd_a = '0;
    end else if (bus.we && (bus.waddr == bus.raddr_a)) begin
      rd_a = bus.wdata;
    end
  end

  // Read/bypass mux B: same priority as port A.
  always_comb begin
    rd_b = mem[bus.raddr_b];
    if (ZERO_REG && (bus.raddr_b == '0)) begin
      rd_b = '0;
    end else if (bus.we && (bus.waddr == bus.raddr_b)) begin
      rd_b = bus.wdata;
    end
  end

  // Output registers: held at zero until the sweep completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= bus.en & bus.we & ~init_done;
      if (bus.en) begin
        rdata_a_q <= init_done ? rd_a : '0;
        rdata_b_q <= init_done ? rd_b : '0;
      end
    end
  end

  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.ready   = init_done;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w (DATA_W=32, ADDR_W=4, ZERO_REG=1,
// INIT_INDEX=1): directed scenarios followed by randomised traffic, all
// checked against a cycle-level reference model of the register file.
module tb_regfile_2r1w;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_2r1w #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .ZERO_REG   (1'b1),
    .INIT_INDEX (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_cnt;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] exp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read port returns once the file is ready.
  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'd0;
    if (bus.we && (int'(bus.waddr) == r)) return bus.wdata;
    return m_mem[r];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] va;
    logic [31:0] vb;
    if (rst) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      exp_a   = 32'd0;
      exp_b   = 32'd0;
      exp_err = 32'd0;
    end else if (!bus.en) begin
      exp_err = 32'd0;
    end else if (!m_ready) begin
      exp_err = 32'(bus.we);
      m_mem[m_cnt] = 32'(m_cnt);
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
      exp_a = 32'd0;
      exp_b = 32'd0;
    end else begin
      exp_err = 32'd0;
      va = m_read(int'(bus.raddr_a));
      vb = m_read(int'(bus.raddr_b));
      if (bus.we && bus.waddr != '0) m_mem[bus.waddr] = bus.wdata;
      exp_a = va;
      exp_b = vb;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".rdata_a"}, bus.rdata_a, exp_a);
    chk({tag, ".rdata_b"}, bus.rdata_b, exp_b);
    chk({tag, ".ready"},   32'(bus.ready), 32'(m_ready));
    chk({tag, ".wr_err"},  32'(bus.wr_err), exp_err);
  endtask

  task automatic idle_inputs();
    bus.en      = 1'b1;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.raddr_a = '0;
    bus.raddr_b = '0;
  endtask

  // Step with en=1 until ready, bounded; checks the number of cycles taken.
  task automatic run_to_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      step(tag);
      n++;
    end
    chk({tag, ".init_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(tag);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    m_ready = 1'b0;
    m_cnt   = 0;
    exp_a   = 32'd0;
    exp_b   = 32'd0;
    exp_err = 32'd0;
    idle_inputs();

    // 1: reset sweep and init values
    do_reset("t1.rst");
    chk("t1.rst_rdata_a", bus.rdata_a, 32'd0);
    chk("t1.rst_ready", 32'(bus.ready), 32'd0);
    run_to_ready("t1.sweep", 16);
    bus.raddr_a = 4'd5;
    bus.raddr_b = 4'd15;
    step("t1.read");
    chk("t1.entry5", bus.rdata_a, 32'd5);
    chk("t1.entry15", bus.rdata_b, 32'd15);

    // 2: write then read back; neighbour untouched
    bus.we = 1'b1; bus.waddr = 4'd3; bus.wdata = 32'hDEADBEEF;
    step("t2.write");
    bus.we = 1'b0; bus.raddr_a = 4'd3; bus.raddr_b = 4'd4;
    step("t2.read");
    chk("t2.entry3", bus.rdata_a, 32'hDEADBEEF);
    chk("t2.entry4", bus.rdata_b, 32'd4);

    // 3: bypass on both ports, then dropped write to entry 0
    bus.we = 1'b1; bus.waddr = 4'd7; bus.wdata = 32'hA5A5_0000;
    bus.raddr_a = 4'd7; bus.raddr_b = 4'd7;
    step("t3.bypass");
    chk("t3.bypass_a", bus.rdata_a, 32'hA5A5_0000);
    chk("t3.bypass_b", bus.rdata_b, 32'hA5A5_0000);
    bus.waddr = 4'd0; bus.wdata = 32'h0000_FFFF; bus.raddr_a = 4'd0;
    step("t3.zero_wr");
    chk("t3.zero_bypass", bus.rdata_a, 32'd0);
    chk("t3.zero_wr_err", 32'(bus.wr_err), 32'd0);
    bus.we = 1'b0;
    step("t3.zero_rd");
    chk("t3.zero_read", bus.rdata_a, 32'd0);

    // 4: write attempted during INIT
    idle_inputs();
    do_reset("t4.rst");
    step("t4.c1");
    step("t4.c2");
    bus.we = 1'b1; bus.waddr = 4'd2; bus.wdata = 32'h1234_5678;
    step("t4.c3");
    chk("t4.wr_err_pulse", 32'(bus.wr_err), 32'd1);
    bus.we = 1'b0;
    step("t4.c4");
    chk("t4.wr_err_clear", 32'(bus.wr_err), 32'd0);
    run_to_ready("t4.sweep", 12);
    bus.raddr_a = 4'd2; bus.raddr_b = 4'd3;
    step("t4.read");
    chk("t4.entry2", bus.rdata_a, 32'd2);
    chk("t4.entry3", bus.rdata_b, 32'd3);

    // 5: reset mid-sweep restarts from entry 0
    idle_inputs();
    do_reset("t5.rst1");
    for (int i = 0; i < 8; i++) step("t5.part");
    do_reset("t5.rst2");
    run_to_ready("t5.sweep", 16);
    for (int i = 0; i < DEPTH / 2; i++) begin
      bus.raddr_a = AW'(2 * i);
      bus.raddr_b = AW'(2 * i + 1);
      step("t5.scan");
      chk("t5.scan_a", bus.rdata_a, 32'(2 * i));
      chk("t5.scan_b", bus.rdata_b, 32'(2 * i + 1));
    end

    // 6: clock enable freezes state and suppresses writes/errors
    bus.raddr_a = 4'd1;
    step("t6.pre");
    bus.en = 1'b0; bus.we = 1'b1; bus.waddr = 4'd9; bus.wdata = 32'd1;
    bus.raddr_a = 4'd6;
    step("t6.frozen");
    chk("t6.hold_a", bus.rdata_a, 32'd1);
    chk("t6.no_err", 32'(bus.wr_err), 32'd0);
    bus.en = 1'b1; bus.we = 1'b0; bus.raddr_a = 4'd9; bus.raddr_b = 4'd6;
    step("t6.post");
    chk("t6.entry9", bus.rdata_a, 32'd9);
    chk("t6.entry6", bus.rdata_b, 32'd6);

    // 6b: five disabled cycles during INIT stretch the sweep to 21 cycles
    idle_inputs();
    do_reset("t6b.rst");
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      bus.en = !(n >= 3 && n < 8);
      step("t6b.sweep");
      n++;
    end
    chk("t6b.init_cycles", 32'(n), 32'd21);

    // 7: randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.we      = $urandom_range(0, 1) == 1;
      bus.raddr_a = AW'($urandom_range(0, 15));
      bus.raddr_b = ($urandom_range(0, 3) == 0) ? bus.raddr_a : AW'($urandom_range(0, 15));
      bus.waddr   = ($urandom_range(0, 3) == 0) ? bus.raddr_b : AW'($urandom_range(0, 15));
      bus.wdata   = $urandom;
      step("t7.rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
